// File: rtl/crc32_pkg.sv
// rtl/crc32_pkg.sv - CRC-32 constants, byte update function and FCS checker FSM states
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } crc32_state_t;

    // Reflected LSB-first update; bit-equivalent to the 256-entry table form.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_fcs_buf.sv
// rtl/crc32_fcs_buf.sv - 4-byte delay line holding the trailing FCS candidate bytes
module crc32_fcs_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        clear,
    input  logic [7:0]  din,
    output logic [7:0]  oldest,
    output logic        full,
    output logic [2:0]  occ,
    output logic [31:0] view
);

    logic [31:0] line_q;
    logic [2:0]  occ_q;

    assign oldest = line_q[7:0];
    assign full   = (occ_q == 3'd4);
    assign occ    = occ_q;

    // Little-endian view of the line as it will look once din is accepted.
    always_comb begin
        view = line_q;
        if (occ_q == 3'd4) begin
            view = {din, line_q[31:8]};
        end else begin
            view[8*occ_q[1:0] +: 8] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (push && clear)) begin
            line_q <= 32'h0;
            occ_q  <= 3'd0;
        end else if (push) begin
            line_q <= view;
            if (occ_q != 3'd4) begin
                occ_q <= occ_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/crc32_fcs_checker.sv
// rtl/crc32_fcs_checker.sv - receive-side CRC-32 FCS checker with frame length and verdict
module crc32_fcs_checker
    import crc32_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             done,
    output logic             crc_ok,
    output logic             runt,
    output logic [31:0]      crc_calc,
    output logic [31:0]      crc_rx,
    output logic [LEN_W-1:0] frame_len
);

    crc32_state_t     state, state_next;
    logic [31:0]      crc_reg, crc_fed, crc_fin;
    logic [LEN_W-1:0] cnt, len_next;
    logic [7:0]       oldest;
    logic             full;
    logic [2:0]       occ;
    logic [31:0]      view;

    crc32_fcs_buf u_buf (
        .clk    (clk),
        .rst    (rst),
        .push   (din_valid),
        .clear  (din_last),
        .din    (din),
        .oldest (oldest),
        .full   (full),
        .occ    (occ),
        .view   (view)
    );

    // Only bytes pushed out of a full line are payload; the line keeps the FCS.
    assign crc_fed  = full ? crc32_byte(crc_reg, oldest) : crc_reg;
    assign crc_fin  = crc_fed ^ CRC32_XOROUT;
    assign len_next = (cnt == {LEN_W{1'b1}}) ? cnt : cnt + LEN_W'(1);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FILL;
            FILL:    state_next = (occ == 3'd3) ? RUN : FILL;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            crc_reg   <= CRC32_INIT;
            cnt       <= '0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            runt      <= 1'b0;
            crc_calc  <= 32'h0;
            crc_rx    <= 32'h0;
            frame_len <= '0;
        end else begin
            done <= 1'b0;
            if (din_valid) begin
                if (din_last) begin
                    state     <= IDLE;
                    crc_reg   <= CRC32_INIT;
                    cnt       <= '0;
                    done      <= 1'b1;
                    crc_calc  <= crc_fin;
                    crc_rx    <= view;
                    frame_len <= len_next;
                    runt      <= (len_next < LEN_W'(5));
                    crc_ok    <= (len_next >= LEN_W'(5)) && (crc_fin == view);
                end else begin
                    state   <= state_next;
                    crc_reg <= crc_fed;
                    cnt     <= len_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc32_fcs_checker.sv
// tb/tb_crc32_fcs_checker.sv - directed self-checking bench for crc32_fcs_checker
module tb_crc32_fcs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h0;
    logic        din_valid = 1'b0;
    logic        din_last = 1'b0;
    logic        done;
    logic        crc_ok;
    logic        runt;
    logic [31:0] crc_calc;
    logic [31:0] crc_rx;
    logic [15:0] frame_len;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [7:0] frame[$];

    always #5 clk = ~clk;

    crc32_fcs_checker #(.LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .done      (done),
        .crc_ok    (crc_ok),
        .runt      (runt),
        .crc_calc  (crc_calc),
        .crc_rx    (crc_rx),
        .frame_len (frame_len)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic l);
        din = b;
        din_valid = v;
        din_last = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(8'h00, 1'b0, 1'b0);
    endtask

    // Gap cycles carry din_last high without din_valid, which must be ignored.
    task automatic send_frame(input bit gaps);
        for (int i = 0; i < frame.size(); i++) begin
            if (gaps && i > 0) drive(8'hA5, 1'b0, 1'b1);
            drive(frame[i], 1'b1, (i == frame.size() - 1));
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp_calc,
                                input logic [31:0] exp_rx, input logic exp_ok,
                                input logic exp_runt, input logic [15:0] exp_len);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".crc_calc"}, crc_calc, exp_calc);
        check({tag, ".crc_rx"}, crc_rx, exp_rx);
        check({tag, ".crc_ok"}, 32'(crc_ok), 32'(exp_ok));
        check({tag, ".runt"}, 32'(runt), 32'(exp_runt));
        check({tag, ".frame_len"}, 32'(frame_len), 32'(exp_len));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".crc_ok"}, 32'(crc_ok), 32'd0);
        check({tag, ".runt"}, 32'(runt), 32'd0);
        check({tag, ".crc_calc"}, crc_calc, 32'h0);
        check({tag, ".crc_rx"}, crc_rx, 32'h0);
        check({tag, ".frame_len"}, 32'(frame_len), 32'd0);
    endtask

    task automatic load_f1(input logic [7:0] last_fcs);
        frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, last_fcs};
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        idle();

        load_f1(8'hCB);
        send_frame(1'b0);
        check_result("f1", 32'hCBF43926, 32'hCBF43926, 1'b1, 1'b0, 16'd13);
        idle();
        check("f1.pulse", 32'(done), 32'd0);
        check("f1.hold", crc_calc, 32'hCBF43926);

        load_f1(8'hCA);
        send_frame(1'b0);
        check_result("f1bad", 32'hCBF43926, 32'hCAF43926, 1'b0, 1'b0, 16'd13);
        idle();

        frame = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
        send_frame(1'b0);
        check_result("zero", 32'hD202EF8D, 32'hD202EF8D, 1'b1, 1'b0, 16'd5);
        frame = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(1'b0);
        check_result("runt3", 32'h00000000, 32'h00CCBBAA, 1'b0, 1'b1, 16'd3);
        idle();

        frame = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(1'b0);
        check_result("runt4", 32'h00000000, 32'h44332211, 1'b0, 1'b1, 16'd4);
        frame = '{8'h5A};
        send_frame(1'b0);
        check_result("runt1", 32'h00000000, 32'h0000005A, 1'b0, 1'b1, 16'd1);
        idle();

        d0 = done_cnt;
        load_f1(8'hCB);
        send_frame(1'b1);
        check_result("gap", 32'hCBF43926, 32'hCBF43926, 1'b1, 1'b0, 16'd13);
        send_frame(1'b0);
        check_result("b2b", 32'hCBF43926, 32'hCBF43926, 1'b1, 1'b0, 16'd13);
        idle();
        idle();
        check("b2b.pulses", 32'(done_cnt - d0), 32'd2);

        for (int i = 0; i < 6; i++) drive(frame[i], 1'b1, 1'b0);
        rst = 1'b1;
        drive(frame[6], 1'b1, 1'b0);
        drive(frame[7], 1'b1, 1'b1);
        check_zero("midrst");
        rst = 1'b0;
        d0 = done_cnt;
        send_frame(1'b0);
        check_result("after_rst", 32'hCBF43926, 32'hCBF43926, 1'b1, 1'b0, 16'd13);
        idle();
        idle();
        check("after_rst.pulses", 32'(done_cnt - d0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc32_fcs_checker.md
# crc32_fcs_checker

Receive-side companion to the byte-serial CRC-32 generator. It consumes a byte stream made of payload followed by a 4-byte FCS, and computes CRC-32 over the payload only. At end of frame it reports the computed and received FCS, the frame length, and a pass/fail verdict. It sits after the byte-stream deframer and ahead of the frame-accept logic.

## Interface
Parameters:
- LEN_W, 16: width of the frame byte counter (saturating).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- din  in  8  stream byte.
- din_valid  in  1  byte present this cycle.
  - The block has no backpressure; every valid byte is accepted.
- din_last  in  1  qualifies din_valid; marks the final FCS byte of the frame.
- done  out  1  one-cycle pulse; the result outputs update in the same cycle.
- crc_ok  out  1  crc_calc == crc_rx, and the frame is not a runt.
- runt  out  1  frame had fewer than 5 bytes (no payload).
- crc_calc  out  32  ~CRC over the payload bytes.
- crc_rx  out  32  received FCS, assembled little-endian (first FCS byte = bits [7:0]).
- frame_len  out  LEN_W  total bytes in the frame including the FCS; saturates at all-ones.

## Operation
- CRC algorithm: reflected polynomial 32'hEDB88320, LSB-first, init 32'hFFFFFFFF, final XOR 32'hFFFFFFFF.
  - Byte update: crc = (crc >> 8) ^ T[crc[7:0] ^ din].
  - The update may be table-based or an 8-step bitwise loop; results must be identical.
- 4-byte delay line: holds the most recent 4 accepted bytes.
  - When a byte is accepted while the line is full (occupancy 4), the oldest byte is fed to the CRC before shifting.
  - At din_last, the line therefore contains exactly the FCS and the CRC register covers only the payload.
- States:
  - IDLE: waiting for the first byte.
  - FILL: occupancy 1–3.
  - RUN: occupancy 4.
  - Every accepted byte with din_last returns the FSM to IDLE.
  - Entering IDLE on last reloads the CRC register with INIT, clears occupancy and clears the byte counter.
- On last (registered into the outputs at the next edge):
  - frame_len = count including this byte.
  - crc_rx = the 4 line bytes, the byte arriving with last included.
  - crc_calc = ~crc_reg.
  - runt = (frame_len < 5).
  - crc_ok = !runt && equal.
  - A zero-payload frame (exactly 4 bytes) is a runt, with crc_calc = 32'h00000000.
  - For runts of 1–3 bytes, crc_rx has the missing high bytes zero.
- Result outputs hold their values until the next done.
- din_last without din_valid is ignored. Cycles with din_valid low do not change state.

## Timing
- Reset values:
  - All outputs are 0.
  - Internally: FSM IDLE, CRC register 32'hFFFFFFFF, occupancy 0, counter 0.
- Latency: a last byte accepted at edge N produces done high for the cycle after edge N, i.e. 1 cycle.
- Back-to-back frames: a valid byte in the cycle directly after a last byte is the first byte of the next frame, with no bubble required.
  - The done of frame k coexists with byte 1 of frame k+1.
- Single-byte frame with din_last on its first byte: done, runt=1, frame_len=1.
- rst mid-frame:
  - Discards the partial frame.
  - No done is produced for it.
  - All outputs return to 0.
- Counter saturation does not affect the CRC or the verdict.

## Structure
- Package crc32_pkg, shared with the generator:
  - CRC32_POLY = 32'hEDB88320
  - CRC32_INIT = 32'hFFFFFFFF
  - CRC32_XOROUT = 32'hFFFFFFFF
  - function crc32_byte(crc, byte) returning the next CRC
  - FSM state enum {IDLE, FILL, RUN}
- One sub-module, crc32_fcs_buf:
  - 4-byte shift line plus occupancy counter.
  - Outputs: oldest byte, full flag, packed 32-bit little-endian view.
- Top level: FSM, CRC register, length counter and result registers.

## Test plan
- Frame "123456789" (31..39 hex) + 26 39 F4 CB, last on CB:
  - done 1 cycle later.
  - crc_calc = crc_rx = 32'hCBF43926, crc_ok=1, frame_len=13.
- Same frame with the final FCS byte CA:
  - crc_rx=32'hCAF43926, crc_ok=0, runt=0.
- Payload 00 + FCS 8D EF 02 D2:
  - crc_calc=32'hD202EF8D, ok=1, len=5.
- Then immediately, with no gap, a 3-byte frame AA BB CC:
  - runt=1, crc_ok=0, frame_len=3, crc_rx=32'h00CCBBAA.
- Frame 1 with din_valid toggled every other cycle, followed back-to-back by frame 1 again:
  - Two done pulses, both with ok=1 and identical outputs.
- rst asserted after byte 6 of frame 1, then the full frame 1 sent:
  - No done for the aborted frame.
  - Outputs 0 during reset.
  - Single done with ok=1, len=13.
